// File: rtl/imem_loader_rv32i_if.sv
// Byte-stream receive link plus instruction-memory write port and core-control status of the loader.
// master = byte source / observer side, slave = the loader itself.
interface imem_loader_rv32i_if #(
    parameter int ADDR_WIDTH = 10
);
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_waddr;
    logic [31:0]           imem_wdata;
    logic                  cpu_hold;
    logic                  done;
    logic                  error;

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, imem_we, imem_waddr, imem_wdata, cpu_hold, done, error
    );

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, imem_we, imem_waddr, imem_wdata, cpu_hold, done, error
    );
endinterface

// File: rtl/imem_loader_rv32i.sv
// Packs a framed little-endian byte stream (A5, CNT_LO, CNT_HI, data, CHK) into 32-bit
// instruction-memory writes and holds the RV32I core in reset until a frame loads cleanly.
module imem_loader_rv32i #(
    parameter int ADDR_WIDTH = 10,
    parameter int BASE_ADDR  = 0
) (
    input logic              clock,
    input logic              reset,
    imem_loader_rv32i_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, LEN0, LEN1, DATA, WRITE, CHK, DONE, ERR
    } state_t;

    localparam logic [7:0]  SYNC = 8'hA5;
    localparam logic [32:0] CAP  = 33'd1 << ADDR_WIDTH;

    state_t      state;
    logic [7:0]  sum;
    logic [7:0]  count_lo;
    logic [16:0] words_left;
    logic [1:0]  byte_idx;

    logic        xfer;
    logic [7:0]  sum_next;
    logic [16:0] count_full;

    assign xfer       = bus.rx_valid & bus.rx_ready;
    assign sum_next   = sum + bus.rx_data;
    assign count_full = {1'b0, bus.rx_data, count_lo};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            sum            <= '0;
            count_lo       <= '0;
            words_left     <= '0;
            byte_idx       <= '0;
            bus.rx_ready   <= 1'b0;
            bus.imem_we    <= 1'b0;
            bus.imem_waddr <= ADDR_WIDTH'(BASE_ADDR);
            bus.imem_wdata <= '0;
            bus.cpu_hold   <= 1'b1;
            bus.done       <= 1'b0;
            bus.error      <= 1'b0;
        end else begin
            bus.imem_we  <= 1'b0;
            bus.rx_ready <= 1'b1;
            case (state)
                IDLE, DONE, ERR: begin
                    if (xfer && bus.rx_data == SYNC) begin
                        state        <= LEN0;
                        sum          <= '0;
                        bus.cpu_hold <= 1'b1;
                        bus.done     <= 1'b0;
                        bus.error    <= 1'b0;
                    end
                end
                LEN0: begin
                    if (xfer) begin
                        count_lo <= bus.rx_data;
                        sum      <= sum_next;
                        state    <= LEN1;
                    end
                end
                LEN1: begin
                    if (xfer) begin
                        sum <= sum_next;
                        if (count_full == '0) begin
                            state <= CHK;
                        end else if (33'(count_full) > CAP) begin
                            // Oversized frame: reject before any data byte is written.
                            state        <= ERR;
                            bus.error    <= 1'b1;
                            bus.cpu_hold <= 1'b1;
                        end else begin
                            state          <= DATA;
                            words_left     <= count_full;
                            byte_idx       <= '0;
                            bus.imem_waddr <= ADDR_WIDTH'(BASE_ADDR);
                        end
                    end
                end
                DATA: begin
                    if (xfer) begin
                        bus.imem_wdata[8*byte_idx +: 8] <= bus.rx_data;
                        sum      <= sum_next;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            state        <= WRITE;
                            bus.imem_we  <= 1'b1;
                            bus.rx_ready <= 1'b0;
                        end
                    end
                end
                WRITE: begin
                    bus.imem_waddr <= bus.imem_waddr + 1'b1;
                    words_left     <= words_left - 17'd1;
                    state          <= (words_left == 17'd1) ? CHK : DATA;
                end
                CHK: begin
                    if (xfer) begin
                        if (sum_next == '0) begin
                            state        <= DONE;
                            bus.done     <= 1'b1;
                            bus.cpu_hold <= 1'b0;
                        end else begin
                            state        <= ERR;
                            bus.error    <= 1'b1;
                            bus.cpu_hold <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader_rv32i.sv
// Self-checking bench for imem_loader_rv32i: directed frame table, random frames against a
// frame-level reference model, plus reset-mid-frame and maximum-count sequences.
module tb_imem_loader_rv32i;
    localparam int AW   = 10;
    localparam int BASE = 0;
    localparam int CAPW = 1 << AW;

    logic clock;
    logic reset;

    imem_loader_rv32i_if #(.ADDR_WIDTH(AW)) bus ();

    imem_loader_rv32i #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int viol  = 0;
    logic armed;

    logic [7:0]  stream[$];
    logic [63:0] exp_q[$];
    logic [63:0] got_q[$];

    typedef struct {
        logic [127:0] b;
        int           n;
        int           nwr;
        logic [31:0]  d0;
        logic         done;
        logic         err;
    } vec_t;
    vec_t tbl[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clock or negedge reset) begin
        if (!reset) armed <= 1'b0;
        else        armed <= 1'b1;
    end

    // Write capture and the ready/write-strobe relationship, sampled mid-cycle.
    always @(negedge clock) begin
        if (reset && bus.imem_we)
            got_q.push_back({32'(bus.imem_waddr), bus.imem_wdata});
        if (reset && armed && (bus.rx_ready !== !bus.imem_we))
            viol++;
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        forever begin
            if (bus.rx_ready) begin
                @(negedge clock);
                break;
            end
            @(negedge clock);
            n++;
            if (n > 50) begin
                check("rx_ready_timeout", 64'(n), 64'(0));
                break;
            end
        end
    endtask

    task automatic send_frame(input bit gaps);
        foreach (stream[i]) begin
            if (gaps && ($urandom % 3 == 0)) begin
                bus.rx_valid = 1'b0;
                bus.rx_data  = 8'($urandom);
                repeat ($urandom_range(1, 2)) @(negedge clock);
            end
            send_byte(stream[i]);
        end
        bus.rx_valid = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    // Frame-level reference: locate sync, decode count, lay out words, verify checksum.
    task automatic model_expect(output logic ed, output logic ee);
        int i = 0;
        int cnt;
        logic [7:0]  sum;
        logic [31:0] w;
        exp_q.delete();
        while (i < stream.size() && stream[i] != 8'hA5) i++;
        i++;
        cnt = int'({stream[i+1], stream[i]});
        sum = stream[i] + stream[i+1];
        i += 2;
        if (cnt > CAPW) begin
            ed = 1'b0;
            ee = 1'b1;
            return;
        end
        for (int k = 0; k < cnt; k++) begin
            w   = {stream[i+3], stream[i+2], stream[i+1], stream[i]};
            sum = sum + stream[i] + stream[i+1] + stream[i+2] + stream[i+3];
            exp_q.push_back({32'((BASE + k) % CAPW), w});
            i += 4;
        end
        sum = sum + stream[i];
        ed  = (sum == 8'h00);
        ee  = !ed;
    endtask

    task automatic compare_writes(input string name);
        int k = -1;
        check({name, "_nwr"}, 64'(got_q.size()), 64'(exp_q.size()));
        if (got_q.size() == exp_q.size() && exp_q.size() > 0) begin
            foreach (exp_q[j]) if (k < 0 && got_q[j] !== exp_q[j]) k = j;
            if (k < 0) k = exp_q.size() - 1;
            check({name, "_wr"}, got_q[k], exp_q[k]);
        end
    endtask

    task automatic run_model_frame(input string name, input bit gaps);
        logic ed, ee;
        model_expect(ed, ee);
        got_q.delete();
        send_frame(gaps);
        compare_writes(name);
        check({name, "_done"}, 64'(bus.done), 64'(ed));
        check({name, "_err"}, 64'(bus.error), 64'(ee));
        check({name, "_hold"}, 64'(bus.cpu_hold), 64'(!ed));
    endtask

    task automatic check_reset_values(input string name);
        check({name, "_ready"}, 64'(bus.rx_ready), 64'(0));
        check({name, "_we"}, 64'(bus.imem_we), 64'(0));
        check({name, "_waddr"}, 64'(bus.imem_waddr), 64'(BASE));
        check({name, "_wdata"}, 64'(bus.imem_wdata), 64'(0));
        check({name, "_hold"}, 64'(bus.cpu_hold), 64'(1));
        check({name, "_done"}, 64'(bus.done), 64'(0));
        check({name, "_err"}, 64'(bus.error), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] b;
        logic [7:0] sum;
        int cnt;

        tbl[0] = '{{64'hA5010013000000EC, 64'h0}, 8, 1, 32'h00000013, 1'b1, 1'b0};
        tbl[1] = '{{64'hA5010013000000ED, 64'h0}, 8, 1, 32'h00000013, 1'b0, 1'b1};
        tbl[2] = '{{32'hA5000000, 96'h0}, 4, 0, 32'h0, 1'b1, 1'b0};
        tbl[3] = '{{24'hA50104, 104'h0}, 3, 0, 32'h0, 1'b0, 1'b1};
        tbl[4] = '{{88'h00FF5AA5010013000000EC, 40'h0}, 11, 1, 32'h00000013, 1'b1, 1'b0};
        tbl[5] = '{{32'hA5000001, 96'h0}, 4, 0, 32'h0, 1'b0, 1'b1};
        tbl[6] = '{{96'hA50200930010001301200027, 32'h0}, 12, 2, 32'h00100093, 1'b1, 1'b0};

        reset        = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (3) @(negedge clock);
        check_reset_values("por");
        reset = 1'b1;
        @(negedge clock);
        check("ready_after_reset", 64'(bus.rx_ready), 64'(1));

        for (int t = 0; t < 7; t++) begin
            stream.delete();
            for (int i = 0; i < tbl[t].n; i++) begin
                b = tbl[t].b[127-8*i -: 8];
                stream.push_back(b);
            end
            got_q.delete();
            send_frame(t[0]);
            check($sformatf("vec%0d_nwr", t), 64'(got_q.size()), 64'(tbl[t].nwr));
            if (tbl[t].nwr > 0 && got_q.size() > 0)
                check($sformatf("vec%0d_w0", t), got_q[0], {32'(BASE), tbl[t].d0});
            check($sformatf("vec%0d_done", t), 64'(bus.done), 64'(tbl[t].done));
            check($sformatf("vec%0d_err", t), 64'(bus.error), 64'(tbl[t].err));
            check($sformatf("vec%0d_hold", t), 64'(bus.cpu_hold), 64'(!tbl[t].done));
        end

        // Three words back to back with rx_valid held high throughout.
        stream.delete();
        stream.push_back(8'hA5);
        stream.push_back(8'h03);
        stream.push_back(8'h00);
        sum = 8'h03;
        for (int i = 0; i < 12; i++) begin
            b = 8'(i * 17 + 1);
            stream.push_back(b);
            sum = sum + b;
        end
        stream.push_back(8'(-sum));
        run_model_frame("three_words", 1'b0);

        // Reset in the middle of a word, then garbage, then a clean reload.
        stream.delete();
        stream.push_back(8'hA5);
        stream.push_back(8'h01);
        stream.push_back(8'h00);
        stream.push_back(8'hAA);
        stream.push_back(8'hBB);
        got_q.delete();
        foreach (stream[i]) send_byte(stream[i]);
        bus.rx_valid = 1'b0;
        reset = 1'b0;
        #1;
        check_reset_values("mid_reset");
        @(negedge clock);
        check("mid_reset_nowr", 64'(got_q.size()), 64'(0));
        reset = 1'b1;
        @(negedge clock);
        stream.delete();
        stream.push_back(8'h00);
        stream.push_back(8'hFF);
        stream.push_back(8'h5A);
        send_frame(1'b0);
        check("garbage_hold", 64'(bus.cpu_hold), 64'(1));
        check("garbage_done", 64'(bus.done), 64'(0));
        check("garbage_nowr", 64'(got_q.size()), 64'(0));
        stream.delete();
        for (int i = 0; i < 8; i++) begin
            b = tbl[0].b[127-8*i -: 8];
            stream.push_back(b);
        end
        run_model_frame("reload", 1'b0);

        // Random frames, occasionally oversized or with a corrupted checksum.
        for (int f = 0; f < 30; f++) begin
            stream.delete();
            repeat ($urandom_range(0, 3)) begin
                b = 8'($urandom);
                if (b == 8'hA5) b = 8'h00;
                stream.push_back(b);
            end
            stream.push_back(8'hA5);
            cnt = ($urandom % 8 == 0) ? int'($urandom_range(CAPW + 1, CAPW + 80))
                                      : int'($urandom_range(0, 6));
            stream.push_back(8'(cnt));
            stream.push_back(8'(cnt >> 8));
            if (cnt <= CAPW) begin
                sum = 8'(cnt) + 8'(cnt >> 8);
                for (int i = 0; i < cnt * 4; i++) begin
                    b = 8'($urandom);
                    stream.push_back(b);
                    sum = sum + b;
                end
                b = 8'(-sum);
                if ($urandom % 4 == 0) b = b + 8'($urandom_range(1, 255));
                stream.push_back(b);
            end
            run_model_frame($sformatf("rnd%0d", f), f[0]);
        end

        // Largest frame that fits: every word address used exactly once.
        stream.delete();
        stream.push_back(8'hA5);
        stream.push_back(8'(CAPW));
        stream.push_back(8'(CAPW >> 8));
        sum = 8'(CAPW) + 8'(CAPW >> 8);
        for (int i = 0; i < CAPW * 4; i++) begin
            b = 8'($urandom);
            stream.push_back(b);
            sum = sum + b;
        end
        stream.push_back(8'(-sum));
        run_model_frame("full_mem", 1'b0);

        check("ready_vs_we", 64'(viol), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
